// File: rtl/simon_pkg.sv
// Shared types for the Simon sequencer: FSM state encoding, colour type and colour decode.
package simon_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ADD      = 3'd1,
      S_SHOW_ON  = 3'd2,
      S_SHOW_OFF = 3'd3,
      S_WAIT_IN  = 3'd4,
      S_WIN      = 3'd5,
      S_LOSE     = 3'd6
   } state_t;

   typedef logic [1:0] color_t;

   localparam int NUM_COLORS = 4;

   function automatic logic [NUM_COLORS-1:0] color_onehot(input color_t c);
      color_onehot    = '0;
      color_onehot[c] = 1'b1;
   endfunction

endpackage

// File: rtl/simon_step_timer.sv
// Up-counter with clear > load > enable priority; done flags count==term combinationally.
// Single cycle update, no backpressure.
module simon_step_timer #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   input  logic [W-1:0] term,
   output logic         done
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en) begin
         count <= count + W'(1);
      end
   end

   assign done = (count == term);

endmodule

// File: rtl/simon_sequencer.sv
// Simon sequencer: appends an LFSR colour each round, plays the sequence on led, checks button entry.
// Optional input timeout with SIMON_TIMEOUT_EN; outputs follow state, round_pass is registered; no backpressure.
module simon_sequencer
   import simon_pkg::*;
#(
   parameter int          MAX_LEN        = 32,
   parameter int unsigned ON_CYCLES      = 25000000,
   parameter int unsigned OFF_CYCLES     = 12500000,
   parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
   input  logic                  clk,
   input  logic                  clr_n,
   input  logic [31:0]           random_num,
   input  logic                  start,
   input  logic                  btn_valid,
   input  logic [1:0]            btn_color,
   output logic [NUM_COLORS-1:0] led,
   output logic                  busy,
   output logic                  round_pass,
   output logic                  game_over,
   output logic                  won,
   output logic [5:0]            score
);

   localparam int SW = 6;
   localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   state_t          state, state_next;
   logic [SW-1:0]   score_next;
   logic [IW-1:0]   idx, idx_next;
   logic            pass_next;
   logic            last;
   logic            t_clear, t_en, t_done;
   logic [31:0]     t_term;
   color_t          seq [MAX_LEN];
   logic            unused_bits;

   assign unused_bits = ^random_num[31:2];
   assign last        = ({{(SW-IW){1'b0}}, idx} == (score - SW'(1)));

   simon_step_timer #(.W(32)) u_timer (
      .clk      (clk),
      .clr_n    (clr_n),
      .clear    (t_clear),
      .load     (1'b0),
      .load_val (32'd0),
      .en       (t_en),
      .term     (t_term),
      .done     (t_done)
   );

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state      <= S_IDLE;
         score      <= '0;
         idx        <= '0;
         round_pass <= 1'b0;
      end else begin
         state      <= state_next;
         score      <= score_next;
         idx        <= idx_next;
         round_pass <= pass_next;
      end
   end

   // Sequence contents are don't-care after reset, so no reset term here.
   always_ff @(posedge clk) begin
      if (state == S_ADD) begin
         seq[score[IW-1:0]] <= random_num[1:0];
      end
   end

   always_comb begin
      state_next = state;
      score_next = score;
      idx_next   = idx;
      pass_next  = 1'b0;
      t_clear    = 1'b0;
      t_en       = 1'b0;
      t_term     = '0;
      led        = '0;
      busy       = 1'b0;
      game_over  = 1'b0;
      won        = 1'b0;

      case (state)
         S_IDLE, S_WIN, S_LOSE: begin
            game_over = (state != S_IDLE);
            won       = (state == S_WIN);
            if (start) begin
               score_next = '0;
               idx_next   = '0;
               state_next = S_ADD;
            end
         end
         S_ADD: begin
            busy       = 1'b1;
            score_next = score + SW'(1);
            idx_next   = '0;
            t_clear    = 1'b1;
            state_next = S_SHOW_ON;
         end
         S_SHOW_ON: begin
            busy   = 1'b1;
            led    = color_onehot(seq[idx]);
            t_en   = 1'b1;
            t_term = 32'(ON_CYCLES - 1);
            if (t_done) begin
               t_clear    = 1'b1;
               state_next = S_SHOW_OFF;
            end
         end
         S_SHOW_OFF: begin
            busy   = 1'b1;
            t_en   = 1'b1;
            t_term = 32'(OFF_CYCLES - 1);
            if (t_done) begin
               t_clear = 1'b1;
               if (last) begin
                  idx_next   = '0;
                  state_next = S_WAIT_IN;
               end else begin
                  idx_next   = idx + IW'(1);
                  state_next = S_SHOW_ON;
               end
            end
         end
         S_WAIT_IN: begin
            t_term = 32'(TIMEOUT_CYCLES - 1);
`ifdef SIMON_TIMEOUT_EN
            t_en   = 1'b1;
`endif
            // A press in the final timeout cycle wins over the timeout.
            if (btn_valid) begin
               if (btn_color != seq[idx]) begin
                  state_next = S_LOSE;
               end else if (!last) begin
                  idx_next = idx + IW'(1);
                  t_clear  = 1'b1;
               end else if (score == SW'(MAX_LEN)) begin
                  state_next = S_WIN;
               end else begin
                  pass_next  = 1'b1;
                  state_next = S_ADD;
               end
            end
`ifdef SIMON_TIMEOUT_EN
            else if (t_done) begin
               state_next = S_LOSE;
            end
`endif
         end
         default: state_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed bench for simon_sequencer with a timeline model of expected outputs per cycle.
module tb_simon_sequencer;

   localparam int MAXL = 3;
   localparam int ONC  = 4;
   localparam int OFFC = 2;

   logic        clk = 1'b0;
   logic        clr_n;
   logic [31:0] random_num;
   logic        start;
   logic        btn_valid;
   logic [1:0]  btn_color;
   logic [3:0]  led;
   logic        busy, round_pass, game_over, won;
   logic [5:0]  score;

   simon_sequencer #(
      .MAX_LEN(MAXL), .ON_CYCLES(ONC), .OFF_CYCLES(OFFC), .TIMEOUT_CYCLES(20)
   ) dut (
      .clk        (clk),
      .clr_n      (clr_n),
      .random_num (random_num),
      .start      (start),
      .btn_valid  (btn_valid),
      .btn_color  (btn_color),
      .led        (led),
      .busy       (busy),
      .round_pass (round_pass),
      .game_over  (game_over),
      .won        (won),
      .score      (score)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Model state: the stored colours and the game's externally visible status.
   logic [1:0] m_seq [$];
   int         m_score = 0;
   int         m_idx = 0;
   logic       m_go = 1'b0, m_won = 1'b0;

   logic       chk_en = 1'b0;
   logic [3:0] exp_led;
   logic       exp_busy, exp_pass, exp_go, exp_won;
   logic [5:0] exp_score;

   int         lit_cycles = 0;
   int         pass_cnt = 0;
   logic [3:0] led_last = 4'd0;

   always @(negedge clk) begin
      if (chk_en) begin
         vectors++;
         if ({led, busy, round_pass, game_over, won, score} !==
             {exp_led, exp_busy, exp_pass, exp_go, exp_won, exp_score}) begin
            miscompares++;
            $display("FAIL cycle t=%0t got led=%b busy=%b pass=%b go=%b won=%b score=%0d want led=%b busy=%b pass=%b go=%b won=%b score=%0d",
                     $time, led, busy, round_pass, game_over, won, score,
                     exp_led, exp_busy, exp_pass, exp_go, exp_won, exp_score);
         end
      end
   end

   always @(negedge clk) begin
      if (clr_n === 1'b1) begin
         if (led != 4'd0) begin
            lit_cycles++;
            led_last = led;
         end
         if (round_pass === 1'b1) pass_cnt++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s got %0d want %0d", name, act, expv);
      end
   endtask

   task automatic cycle(input logic [3:0] l, input logic b, input logic p,
                        input logic g, input logic w);
      exp_led = l; exp_busy = b; exp_pass = p; exp_go = g; exp_won = w;
      exp_score = 6'(m_score);
      @(posedge clk);
      #1;
      start      = 1'b0;
      btn_valid  = 1'b0;
      random_num = $urandom();
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(4'd0, 1'b0, 1'b0, m_go, m_won);
   endtask

   task automatic playback(input bit noisy);
      foreach (m_seq[i]) begin
         repeat (ONC) begin
            if (noisy) begin
               btn_valid = 1'b1;
               btn_color = m_seq[i] + 2'd1;
            end
            cycle(4'd1 << m_seq[i], 1'b1, 1'b0, 1'b0, 1'b0);
         end
         repeat (OFFC) cycle(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      m_idx = 0;
   endtask

   task automatic add_round(input logic [1:0] rnd, input logic p, input bit noisy);
      random_num[1:0] = rnd;
      cycle(4'd0, 1'b1, p, 1'b0, 1'b0);
      m_seq.push_back(rnd);
      m_score++;
      playback(noisy);
   endtask

   task automatic do_start(input logic [1:0] rnd);
      start = 1'b1;
      cycle(4'd0, 1'b0, 1'b0, m_go, m_won);
      m_score = 0; m_seq.delete(); m_go = 1'b0; m_won = 1'b0;
      add_round(rnd, 1'b0, 1'b0);
   endtask

   // Returns 1 when the press completed a round that is not the last one.
   task automatic press(input logic [1:0] c, output bit next_round);
      next_round = 1'b0;
      btn_valid  = 1'b1;
      btn_color  = c;
      cycle(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (c != m_seq[m_idx]) begin
         m_go = 1'b1; m_won = 1'b0;
      end else if (m_idx < m_score - 1) begin
         m_idx++;
      end else if (m_score == MAXL) begin
         m_go = 1'b1; m_won = 1'b1;
      end else begin
         next_round = 1'b1;
      end
   endtask

   initial begin
      bit nr;
      clr_n = 1'b0; start = 1'b0; btn_valid = 1'b0; btn_color = 2'd0; random_num = 32'd0;
      repeat (2) @(posedge clk);
      #1 clr_n = 1'b1;
      #1;
      chk("reset_led", led, 0);
      chk("reset_score", score, 0);
      chk("reset_game_over", game_over, 0);
      chk("reset_busy", busy, 0);
      chk("reset_won", won, 0);
      chk("reset_round_pass", round_pass, 0);
      chk_en = 1'b1;
      idle(3);

      // First round: colour 2 lit 4 cycles, dark 2, then waiting.
      do_start(2'd2);
      chk("r1_lit_cycles", lit_cycles, 4);
      chk("r1_led", led_last, 4'b0100);
      chk("r1_score", score, 1);
      chk("r1_busy", busy, 0);
      idle(2);

      press(2'd2, nr);
      chk("r1_next_round", nr, 1);
      add_round(2'd1, 1'b1, 1'b0);
      chk("r2_pass_cnt", pass_cnt, 1);
      chk("r2_score", score, 2);
      chk("r2_lit_cycles", lit_cycles, 12);
      chk("r2_led_last", led_last, 4'b0010);

      // Wrong press at idx 0 of round 2.
      press(2'd3, nr);
      idle(3);
      chk("lose_game_over", game_over, 1);
      chk("lose_won", won, 0);
      chk("lose_score", score, 2);

      do_start(2'd3);
      chk("restart_score", score, 1);
      press(2'd3, nr);
      add_round(2'd0, 1'b1, 1'b0);
      press(2'd3, nr);
      press(2'd0, nr);
      add_round(2'd1, 1'b1, 1'b1);
      press(2'd3, nr);
      press(2'd0, nr);
      press(2'd1, nr);
      idle(3);
      chk("win_won", won, 1);
      chk("win_game_over", game_over, 1);
      chk("win_score", score, 3);
      chk("win_pass_cnt", pass_cnt, 3);

      // Reset asserted partway through SHOW_ON.
      start = 1'b1;
      cycle(4'd0, 1'b0, 1'b0, m_go, m_won);
      m_score = 0; m_seq.delete(); m_go = 1'b0; m_won = 1'b0;
      random_num[1:0] = 2'd1;
      cycle(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      m_score = 1; m_seq.push_back(2'd1);
      repeat (2) cycle(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
      chk_en = 1'b0;
      #2 clr_n = 1'b0;
      #1;
      chk("arst_led", led, 0);
      chk("arst_busy", busy, 0);
      chk("arst_score", score, 0);
      chk("arst_game_over", game_over, 0);
      chk("arst_round_pass", round_pass, 0);
      @(posedge clk);
      #1 clr_n = 1'b1;
      m_score = 0; m_seq.delete(); m_go = 1'b0; m_won = 1'b0;
      chk_en = 1'b1;
      idle(2);

      do_start(2'd2);
`ifdef SIMON_TIMEOUT_EN
      idle(20);
      m_go = 1'b1; m_won = 1'b0;
      idle(2);
      chk("timeout_game_over", game_over, 1);
      chk("timeout_won", won, 0);
`else
      idle(100);
      chk("no_timeout_game_over", game_over, 0);
      chk("no_timeout_busy", busy, 0);
      press(2'd2, nr);
      add_round(2'd3, 1'b1, 1'b0);
      chk("no_timeout_score", score, 2);
`endif

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
